jstk_poller: RTL
================

# jstk_poller

Polling controller that sits directly upstream and downstream of the 40-bit SPI master for the PMOD joystick. It periodically fires the master's `trigger`, drives the outgoing 5-byte command frame, and waits for the transfer to finish by watching `cs`. It then decodes the received frame into X/Y position, buttons and paddle direction for the Pong game logic.

## Interface
- `POLL_CYCLES`, 500000: clk cycles from one poll start to the next (10 ms at 50 MHz); must be > 4096.
- `TIMEOUT_CYCLES`, 8192: maximum clk cycles spent in REQ+XFER before abort.
- `CENTER`, 512: nominal joystick rest value (10-bit).
- `DEADZONE`, 64: half-width of the no-move band around `CENTER`.
- `clk`  in  1  50 MHz global clock, same as SPI master.
- `rst_n`  in  1  asynchronous, active-low reset.
- `led`  in  2  LED1/LED2 request; sampled at poll start.
- `trigger`  out  1  to SPI master `trigger`.
- `out_bytes`  out  40  to SPI master `out_bytes`.
- `in_bytes`  in  40  from SPI master `in_bytes`.
- `spi_cs`  in  1  from SPI master `cs` (1 = idle); generated in the SPI clock domain.
- `x`, `y`  out  10 each  decoded position.
- `btn`  out  3  {btn2, btn1, stick button}.
- `paddle_up`, `paddle_down`  out  1 each  Y-derived direction.
- `valid`  out  1  one-cycle pulse on a new sample.
- `err`  out  1  one-cycle pulse on a timeout abort.

## Operation
- `spi_cs` passes through a 2-flop synchronizer (reset value 1) to produce `cs_s`. All FSM decisions use `cs_s`.
- States: IDLE, REQ, XFER, LATCH.
  - IDLE: `poll_ctr` counts up. When it reaches `POLL_CYCLES-1`: set `poll_ctr` to 0, register `out_bytes = {6'b100000, led[1:0], 32'h0}`, and go to REQ.
  - REQ: `trigger` = 1. When `cs_s` = 0, go to XFER.
  - XFER: `trigger` = 0. When `cs_s` = 1, go to LATCH.
  - LATCH: capture `in_bytes`, update outputs, pulse `valid`, return to IDLE.
- `poll_ctr` keeps counting in every state, so the poll period is fixed regardless of transfer length.
- `to_ctr` clears on entry to REQ and increments in REQ and XFER. At `TIMEOUT_CYCLES-1`: pulse `err`, drop `trigger`, return to IDLE. Outputs keep their previous values.
- Decode of frame F = `in_bytes`, first byte received in F[39:32]:
  - `x` = {F[25:24], F[39:32]}
  - `y` = {F[9:8], F[23:16]}
  - `btn` = F[2:0]
- Paddle direction:
  - `paddle_up` = `y` > `CENTER+DEADZONE`.
  - `paddle_down` = `y` < `CENTER-DEADZONE`.
  - Both are never 1 together. Comparisons are unsigned 11-bit to avoid wrap.
- Reset values: `trigger` 0, `out_bytes` 40'h80_0000_0000, `x` and `y` = `CENTER`, `btn` 0, `paddle_*` 0, `valid` 0, `err` 0. State IDLE, counters 0.
- Reset mid-transfer: return to IDLE at once. The SPI master finishes its frame on its own, and the next poll starts normally.
- A `led` change during REQ/XFER is applied at the next poll.

## Timing
- The first poll leaves IDLE `POLL_CYCLES` cycles after reset release.
- REQ→XFER takes up to 64 cycles (one SPI clock) plus 2 sync cycles.
- The SPI master updates `in_bytes` at least one SPI clock before raising `cs`. After the 2-cycle sync, `in_bytes` is therefore stable in LATCH.
- `x`, `y`, `btn`, `paddle_*` and `valid` are registered and update together, on the cycle after LATCH.
- A nominal transaction (40 SPI clocks × 64 cycles + overhead) completes well inside `TIMEOUT_CYCLES`.

## Configuration
- `JSTK_DEADZONE_EN` defined: when `y` (or `x`) lies within `CENTER±DEADZONE` inclusive, the reported `y` (or `x`) is snapped to `CENTER`.
- Not defined: `x` and `y` are reported raw. The paddle outputs still use the deadzone thresholds in both builds.

## Test plan
- Reset, SPI model present, `led`=2'b01 → after `POLL_CYCLES`: `trigger` high, `out_bytes`=40'h81_0000_0000, and `trigger` falls once `cs_s`=0.
- Slave returns bytes 0xFF,0x03,0x00,0x00,0x05 → `x`=1023, `y`=0, `btn`=3'b101, `paddle_down`=1, `paddle_up`=0, single `valid` pulse.
- Slave returns Y=540 (0x1C,0x02), `JSTK_DEADZONE_EN` defined → `y`=512, no paddle motion; undefined → `y`=540, no paddle motion.
- `spi_cs` held high (no master) → `err` pulses after `TIMEOUT_CYCLES`, `x`/`y` unchanged, next poll retries.
- `rst_n` asserted during XFER → all outputs return to reset values at once; next `valid` arrives after a full `POLL_CYCLES`.
- Back-to-back polls → `valid` spacing exactly `POLL_CYCLES` cycles.

Source files
------------

// File: rtl/jstk_poller.sv
// jstk_poller
// Polling controller for the PMOD joystick behind a 40-bit SPI master.
// It fires the master's trigger once every POLL_CYCLES clocks and drives the
// 5-byte command frame. It then follows the transfer through the master's
// chip select and decodes the received frame into position, buttons and a
// paddle direction.
//
// Optional feature (compile-time macro JSTK_DEADZONE_EN):
//   defined     - x/y values inside CENTER +/- DEADZONE (inclusive) are
//                 reported as CENTER.
//   not defined - x/y are reported raw.
//   The paddle outputs use the deadzone thresholds in both builds.
//
// Ports:
//   clk          in   system clock (same clock as the SPI master)
//   rst_n        in   asynchronous active-low reset
//   led[1:0]     in   LED request, sampled when a poll starts
//   trigger      out  start pulse/level to the SPI master (high in REQ)
//   out_bytes    out  command frame to the SPI master
//   in_bytes     in   frame received by the SPI master
//   spi_cs       in   SPI master chip select (1 = idle), asynchronous here
//   x, y         out  decoded 10-bit position
//   btn[2:0]     out  {btn2, btn1, stick button}
//   paddle_up    out  y above CENTER+DEADZONE
//   paddle_down  out  y below CENTER-DEADZONE
//   valid        out  one-cycle pulse when a new sample is presented
//   err          out  one-cycle pulse when a transfer is aborted on timeout
//   dbg_state    out  current FSM state (IDLE=0, REQ=1, XFER=2, LATCH=3)
//
// Handshake with the SPI master: trigger stays high in REQ until the
// synchronised chip select drops. The transfer counts as complete when the
// chip select rises again. There is no ready/valid back-pressure. valid is a
// pure one-cycle event qualifying x/y/btn/paddle_* in the same cycle.
module jstk_poller #(
   parameter int POLL_CYCLES    = 500000,
   parameter int TIMEOUT_CYCLES = 8192,
   parameter int CENTER         = 512,
   parameter int DEADZONE       = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  led,
   output logic        trigger,
   output logic [39:0] out_bytes,
   input  logic [39:0] in_bytes,
   input  logic        spi_cs,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic [2:0]  btn,
   output logic        paddle_up,
   output logic        paddle_down,
   output logic        valid,
   output logic        err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      XFER  = 2'd2,
      LATCH = 2'd3
   } state_t;

   localparam int PW = $clog2(POLL_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   // Thresholds are 11 bits wide so CENTER+DEADZONE cannot wrap.
   // The lower bound is clamped at zero.
   localparam int HI_I = CENTER + DEADZONE;
   localparam int LO_I = (CENTER > DEADZONE) ? (CENTER - DEADZONE) : 0;
   localparam logic [10:0] HI  = 11'(HI_I);
   localparam logic [10:0] LO  = 11'(LO_I);
   localparam logic [9:0]  CTR = 10'(CENTER);

   state_t state, next_state;

   logic [PW-1:0] poll_ctr;
   logic [TW-1:0] to_ctr;
   logic          cs_meta, cs_s;
   logic          poll_hit, timeout_hit;
   logic          start_poll, abort;

   logic [9:0] x_raw, y_raw, x_dec, y_dec;
   logic       up_dec, dn_dec;
   logic       unused_bits;

   // Chip select comes from the SPI clock domain; it idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_meta <= 1'b1;
         cs_s    <= 1'b1;
      end else begin
         cs_meta <= spi_cs;
         cs_s    <= cs_meta;
      end
   end

   assign poll_hit    = (poll_ctr == POLL_LAST);
   assign timeout_hit = (to_ctr == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      start_poll = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (poll_hit) begin
               next_state = REQ;
               start_poll = 1'b1;
            end
         end
         REQ: begin
            if (timeout_hit) begin
               next_state = IDLE;
               abort      = 1'b1;
            end else if (!cs_s) begin
               next_state = XFER;
            end
         end
         XFER: begin
            if (timeout_hit) begin
               next_state = IDLE;
               abort      = 1'b1;
            end else if (cs_s) begin
               next_state = LATCH;
            end
         end
         LATCH:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign trigger   = (state == REQ);
   assign dbg_state = state;

   // The poll counter free-runs in every state so the poll period does not
   // depend on how long a transfer takes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_ctr <= '0;
      end else if (poll_hit) begin
         poll_ctr <= '0;
      end else begin
         poll_ctr <= poll_ctr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_ctr <= '0;
      end else if (start_poll) begin
         to_ctr <= '0;
      end else if (state == REQ || state == XFER) begin
         to_ctr <= to_ctr + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_bytes <= 40'h80_0000_0000;
      end else if (start_poll) begin
         out_bytes <= {6'b100000, led, 32'h0};
      end
   end

   // Frame decode. The first byte received is in_bytes[39:32].
   assign x_raw  = {in_bytes[25:24], in_bytes[39:32]};
   assign y_raw  = {in_bytes[9:8],   in_bytes[23:16]};
   assign up_dec = ({1'b0, y_raw} > HI);
   assign dn_dec = ({1'b0, y_raw} < LO);

`ifdef JSTK_DEADZONE_EN
   assign x_dec = (({1'b0, x_raw} >= LO) && ({1'b0, x_raw} <= HI)) ? CTR : x_raw;
   assign y_dec = (({1'b0, y_raw} >= LO) && ({1'b0, y_raw} <= HI)) ? CTR : y_raw;
`else
   assign x_dec = x_raw;
   assign y_dec = y_raw;
`endif

   // Bits of the frame that carry no information for this block.
   assign unused_bits = ^{in_bytes[31:26], in_bytes[15:10], in_bytes[7:3]};

   // Sample outputs update together on the cycle after LATCH. On a timeout
   // abort they keep their previous values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x           <= CTR;
         y           <= CTR;
         btn         <= 3'b000;
         paddle_up   <= 1'b0;
         paddle_down <= 1'b0;
         valid       <= 1'b0;
         err         <= 1'b0;
      end else begin
         valid <= (state == LATCH);
         err   <= abort;
         if (state == LATCH) begin
            x           <= x_dec;
            y           <= y_dec;
            btn         <= in_bytes[2:0];
            paddle_up   <= up_dec;
            paddle_down <= dn_dec;
         end
      end
   end

endmodule
